write_back_stage: RTL

Final stage of the five-stage pipelined MIPS core: the writer side of the register-file write port that instruction decode exposes (`write_result`, `write_addr`, `register_write`). It holds the MEM/WB pipeline register and selects ALU result, extracted load data, or link address. It suppresses writes to `$0` and bubbles, counts retired instructions, and runs a halt/drain state machine that stops the core cleanly.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/load_extract.sv | 28 ++
 rtl/write_back_stage.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: load encodings, the halt word,
// the link register index and the write-back FSM states.
package mips_pkg;

  localparam logic [2:0] LOAD_LW  = 3'd0;
  localparam logic [2:0] LOAD_LB  = 3'd1;
  localparam logic [2:0] LOAD_LBU = 3'd2;
  localparam logic [2:0] LOAD_LH  = 3'd3;
  localparam logic [2:0] LOAD_LHU = 3'd4;

  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
  localparam logic [4:0]  REG_RA     = 5'd31;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } wb_state_t;

endpackage

// File: rtl/load_extract.sv
// Little-endian load data extraction: picks the byte or half addressed by
// the low address bits out of an aligned word and sign/zero extends it.
module load_extract
  import mips_pkg::*;
(
  input  logic [31:0] mem_data,
  input  logic [1:0]  offset,
  input  logic [2:0]  load_type,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select, then extend by load type; unused encodings behave as LW.
  always_comb begin
    byte_sel = mem_data[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? mem_data[31:16] : mem_data[15:0];
    case (load_type)
      LOAD_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      LOAD_LBU: data = {24'd0, byte_sel};
      LOAD_LH:  data = {{16{half_sel[15]}}, half_sel};
      LOAD_LHU: data = {16'd0, half_sel};
      default:  data = mem_data;
    endcase
  end

endmodule

// File: rtl/write_back_stage.sv
// MEM/WB register and write-back stage: result select, register-file write
// port, retired-instruction counter and the halt/drain state machine.
module write_back_stage
  import mips_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               valid_m,
  input  logic               register_write_m,
  input  logic               mem_to_reg_m,
  input  logic               link_m,
  input  logic               halt_m,
  input  logic [2:0]         load_type_m,
  input  logic [31:0]        alu_result_m,
  input  logic [31:0]        mem_data_m,
  input  logic [31:0]        pc_plus4_m,
  input  logic [4:0]         write_addr_m,
  output logic signed [31:0] write_result,
  output logic [4:0]         write_addr,
  output logic               register_write,
  output logic               halted,
  output logic [31:0]        retired_count
);

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES);

  wb_state_t   state_q, state_d;
  logic [3:0]  drain_q, drain_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  addr_q, addr_d;
  logic        we_q, we_d;
  logic        halted_q, halted_d;
  logic [31:0] count_q, count_d;

  logic [31:0] load_data;
  logic [31:0] mux_result;
  logic [4:0]  mux_addr;
  logic        mux_we;

  load_extract u_load_extract (
    .mem_data  (mem_data_m),
    .offset    (alu_result_m[1:0]),
    .load_type (load_type_m),
    .data      (load_data)
  );

  // Result/address select (link > load > ALU) and the write enable, which
  // drops bubbles, halts and any write aimed at $0.
  always_comb begin
    mux_result = alu_result_m;
    mux_addr   = write_addr_m;
    if (link_m) begin
      mux_result = pc_plus4_m;
      mux_addr   = REG_RA;
    end else if (mem_to_reg_m) begin
      mux_result = load_data;
    end
    mux_we = valid_m & (register_write_m | link_m) & ~halt_m & (mux_addr != 5'd0);
  end

  // Next state of the WB register, counters and FSM. Outside RUN the stage
  // only drains; a halt is captured only on a cycle with neither stall nor flush.
  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    result_d = result_q;
    addr_d   = addr_q;
    we_d     = we_q;
    halted_d = halted_q;
    count_d  = count_q;
    case (state_q)
      RUN: begin
        if (flush) begin
          result_d = '0;
          addr_d   = '0;
          we_d     = 1'b0;
        end else if (!stall) begin
          if (valid_m && !halt_m) begin
            result_d = mux_result;
            addr_d   = mux_addr;
            we_d     = mux_we;
          end else begin
            result_d = '0;
            addr_d   = '0;
            we_d     = 1'b0;
          end
          if (valid_m && count_q != 32'hFFFF_FFFF)
            count_d = count_q + 32'd1;
          if (valid_m && halt_m) begin
            state_d = DRAIN;
            drain_d = '0;
          end
        end
      end
      DRAIN: begin
        result_d = '0;
        addr_d   = '0;
        we_d     = 1'b0;
        if (drain_q == DRAIN_LAST) begin
          state_d  = HALTED;
          halted_d = 1'b1;
        end else begin
          drain_d = drain_q + 4'd1;
        end
      end
      HALTED: begin
        result_d = '0;
        addr_d   = '0;
        we_d     = 1'b0;
        halted_d = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RUN;
      drain_q  <= '0;
      result_q <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      result_q <= result_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      halted_q <= halted_d;
      count_q  <= count_d;
    end
  end

  assign write_result   = result_q;
  assign write_addr     = addr_q;
  assign register_write = we_q;
  assign halted         = halted_q;
  assign retired_count  = count_q;

endmodule
